// File: rtl/byte_word_packer.sv
// Packs an accepted byte stream little-endian into LANES-byte words and queues them in a FIFO.
// Latency: word visible 1 cycle after its final byte; no input backpressure, words that find the FIFO full are dropped.
module byte_word_packer #(
    parameter int LANES      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [7:0]                         in_data,
    input  logic                               in_valid,
    input  logic                               in_last,
    output logic [8*LANES-1:0]                 out_data,
    output logic [LANES-1:0]                   out_keep,
    output logic                               out_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               overflow,
    input  logic                               ovf_clr
);

    localparam int CNT_W = $clog2(LANES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [8*LANES-1:0] dat;
        logic [LANES-1:0]   keep;
        logic               last;
    } word_t;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LANES-1:0][7:0] lanes_q, lanes_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  ovf_q, ovf_d;
    word_t                 mem_q [FIFO_DEPTH];

    word_t                 word_c;
    word_t                 head_c;
    logic                  complete_c;
    logic                  empty_c;
    logic                  full_c;
    logic                  push_c;
    logic                  pop_c;
    logic                  drop_c;

    // Assembler: the completed word is the stored lanes with the current byte overlaid at lane cnt.
    always_comb begin
        cnt_d      = cnt_q;
        lanes_d    = lanes_q;
        word_c     = '0;
        complete_c = 1'b0;
        if (in_valid) begin
            word_c.dat               = lanes_q;
            word_c.dat[8*cnt_q +: 8] = in_data;
            for (int k = 0; k < LANES; k++) begin
                word_c.keep[k] = (k <= int'(cnt_q));
            end
            word_c.last = in_last;
            complete_c  = (cnt_q == CNT_W'(LANES - 1)) || in_last;
            if (complete_c) begin
                cnt_d   = '0;
                lanes_d = '0;
            end else begin
                lanes_d[cnt_q] = in_data;
                cnt_d          = cnt_q + 1'b1;
            end
        end
    end

    assign empty_c = (level_q == '0);
    assign full_c  = (level_q == LVL_W'(FIFO_DEPTH));
    assign pop_c   = !empty_c && out_ready;
    // A full FIFO can still take a word when the head leaves on the same edge.
    assign push_c  = complete_c && (!full_c || pop_c);
    assign drop_c  = complete_c && !push_c;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_c, pop_c})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (drop_c) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            lanes_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            lanes_q  <= lanes_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the level is zero.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= word_c;
        end
    end

    assign head_c     = mem_q[rd_ptr_q];
    assign out_valid  = !empty_c;
    assign out_data   = empty_c ? '0 : head_c.dat;
    assign out_keep   = empty_c ? '0 : head_c.keep;
    assign out_last   = empty_c ? 1'b0 : head_c.last;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;

endmodule

// File: doc/byte_word_packer.md
# byte_word_packer

Downstream consumer of the 8-bit registered byte stream (`data_out`/`valid`) produced by the input stage. It packs consecutive bytes little-endian into `LANES`-byte words, closes short words on a frame-end marker, and buffers completed words in a small synchronous FIFO. The FIFO presents them on a valid/ready output port. The upstream stage has no backpressure, so input bytes are always accepted; words that cannot be buffered are dropped and flagged.

## Interface
- `LANES`, default 4: bytes per output word; must be ≥2.
- `FIFO_DEPTH`, default 4: word entries in the output FIFO; must be a power of 2 and ≥2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_data` in 8: byte from the upstream stage.
- `in_valid` in 1: `in_data` is valid this cycle and is always accepted.
- `in_last` in 1: the byte is the last of a frame. Qualified by `in_valid`.
- `out_data` out 8*LANES: head word. Lane k occupies bits [8k+7:8k].
- `out_keep` out LANES: per-lane byte-valid for the head word, contiguous from lane 0.
- `out_last` out 1: the head word closes a frame.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: downstream accepts the head word.
- `fifo_level` out $clog2(FIFO_DEPTH+1): number of stored words.
- `overflow` out 1: sticky; a completed word was dropped.
- `ovf_clr` in 1: synchronous clear of `overflow`.

## Operation
- **Assembler:** a byte counter `cnt` (0..LANES-1) plus a LANES-byte shift/lane register.
  - An accepted byte goes into lane `cnt`.
  - Lanes not yet written read as 0x00.
- **Word completion:** a word completes on an accepted byte when `cnt==LANES-1` or `in_last==1`.
  - Completed word = the assembled lanes plus the current byte.
  - `keep` = (1<<(cnt+1))-1.
  - `last` = `in_last`.
  - `cnt` returns to 0 and the lane register clears.
- **Non-completing byte:** store the byte and increment `cnt`.
- **Push condition:** a completed word is pushed if `fifo_level<FIFO_DEPTH`, or if a pop occurs in the same cycle (the simultaneous push/pop on a full FIFO is legal).
- **Drop:** if the push is not allowed, discard the word and set `overflow`. The assembler still restarts at `cnt=0`.
- **Pop:** occurs when `out_valid && out_ready`.
  - `out_data`, `out_keep` and `out_last` are held stable while `out_valid && !out_ready`.
- **FIFO storage:** circular buffer with read/write pointers that wrap modulo `FIFO_DEPTH`, plus an explicit level counter. Word order is strictly preserved.
- **`fifo_level` update:** +1 on push only, −1 on pop only, unchanged on push and pop together.
- **`overflow`:** set by a drop.
  - `ovf_clr` clears it.
  - If a drop and `ovf_clr` occur in the same cycle, the set wins.
- **Idle input:** `in_last` without `in_valid` is ignored. No timeout flush exists; a partial word waits for more bytes.
- **Reset (asserted at any time, including mid-frame or with the FIFO non-empty):**
  - FIFO empties; pointers, level and `cnt` go to 0; the lane register clears.
  - Outputs: `out_valid`=0, `out_data`=0, `out_keep`=0, `out_last`=0, `fifo_level`=0, `overflow`=0.
  - Buffered and partially assembled data is lost.
- **Empty-FIFO output values:** `out_data`, `out_keep` and `out_last` read 0 while the FIFO is empty (masked).

## Timing
- **Input to output latency:** a completing byte accepted at edge N gives `out_valid`=1 with that word after edge N, provided the FIFO was empty. That is 1 cycle after the byte is presented.
- **No bypass:** a word is never visible at the output in the same cycle its final byte is presented.
- **Throughput:** one byte per cycle in; one word per cycle out.
- **Pop timing:** pop at edge N exposes the next word (or `out_valid`=0) after edge N.
- **`fifo_level` and `overflow`:** update on the same edge as the push, pop or drop that causes them.
- **Reset release:** first byte is accepted on the first rising edge with `reset_n`=1.

## Test plan
- **Full word:** bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles, `out_ready`=1 → one cycle after 0x44: `out_data`=0x44332211, `out_keep`=0xF, `out_last`=0, `fifo_level`=1, then 0 after the pop.
- **Short frame:** 0xAA, then 0xBB with `in_last` → `out_data`=0x0000BBAA, `out_keep`=0x3, `out_last`=1. A following single byte 0xCC with `in_last` → `out_data`=0x000000CC, `out_keep`=0x1, `out_last`=1.
- **Overflow:**
  - Stimulus: `out_ready`=0; 20 bytes 0x00..0x13, giving 5 words.
  - After the fourth word: `fifo_level`=4.
  - Fifth word: dropped, `overflow`=1.
  - Then raise `out_ready`: words drain in order 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, then `out_valid`=0.
- **Full FIFO with simultaneous push/pop:**
  - Stimulus: FIFO full, `out_ready`=1 on the same cycle a new word completes.
  - Required: word accepted, `fifo_level` stays 4, `overflow` unchanged.
  - Pulse `ovf_clr` → `overflow`=0. A drop coinciding with `ovf_clr` → `overflow`=1.
- **Reset mid-operation:**
  - Stimulus: 2 words buffered plus 3 bytes assembled, then assert `reset_n`=0 asynchronously between edges.
  - Immediately: `out_valid`=0, `fifo_level`=0, `overflow`=0.
  - After release, bytes 0x01..0x04 → `out_data`=0x04030201 with `out_keep`=0xF (no stale lanes).
- **Stall stability:** `out_valid`=1 with `out_ready`=0 held for 5 cycles while more bytes arrive → `out_data`, `out_keep` and `out_last` unchanged throughout.
